// File: rtl/ffa_limb_serial.sv
// ffa_limb_serial: limb-serial modular adder/subtractor over GF(P).
// One LIMB-bit slice per clock, LSB first, with start/done handshake.
// Both candidate results (raw S and P-corrected D) are built in parallel,
// and the final edge selects one of them.
// Build option: define FFA_SUB_EN to enable subtract mode (mode=1 -> a-b mod P).
// Without it the subtract path is not built and mode is ignored.
module ffa_limb_serial #(
  parameter int unsigned      WIDTH = 256,
  parameter int unsigned      LIMB  = 64,
  parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

  if ((WIDTH % LIMB) != 0) begin : g_bad_cfg
    $error("ffa_limb_serial: WIDTH must be a multiple of LIMB");
  end

  typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic [WIDTH-1:0] s_q, d_q;
  logic             r1_q;   // add: carry of a+b chain; sub: borrow of a-b chain
  logic             r2_q;   // add: borrow of S-P chain; sub: carry of S+P chain
  logic [WIDTH-1:0] out_q;
  logic             done_q, busy_q;

`ifdef FFA_SUB_EN
  logic mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  logic [LIMB-1:0]  a_k, b_k, p_k, s_k, d_k;
  logic [LIMB:0]    t1, t2;
  logic             r1_d, r2_d;
  logic [WIDTH-1:0] s_ins, d_ins;
  logic             sel_d;

  assign a_k = a_q[LIMB-1:0];
  assign b_k = b_q[LIMB-1:0];
  assign p_k = p_q[LIMB-1:0];

  // Per-limb arithmetic for both chains, plus final D/S selection.
  always_comb begin
    t1    = {1'b0, a_k} + {1'b0, b_k} + {{LIMB{1'b0}}, r1_q};
    s_k   = t1[LIMB-1:0];
    r1_d  = t1[LIMB];
    t2    = {1'b0, s_k} - {1'b0, p_k} - {{LIMB{1'b0}}, r2_q};
    d_k   = t2[LIMB-1:0];
    r2_d  = t2[LIMB];
    sel_d = r1_q || !r2_q;
`ifdef FFA_SUB_EN
    if (mode_q) begin
      t1    = {1'b0, a_k} - {1'b0, b_k} - {{LIMB{1'b0}}, r1_q};
      s_k   = t1[LIMB-1:0];
      r1_d  = t1[LIMB];
      t2    = {1'b0, s_k} + {1'b0, p_k} + {{LIMB{1'b0}}, r2_q};
      d_k   = t2[LIMB-1:0];
      r2_d  = t2[LIMB];
      sel_d = r1_q;
    end
`endif
    s_ins = '0;
    d_ins = '0;
    s_ins[WIDTH-1 -: LIMB] = s_k;
    d_ins[WIDTH-1 -: LIMB] = d_k;
  end

  // Control FSM and limb-serial datapath with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
      d_q     <= '0;
      r1_q    <= 1'b0;
      r2_q    <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FFA_SUB_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            p_q     <= P;
            r1_q    <= 1'b0;
            r2_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
`ifdef FFA_SUB_EN
            mode_q  <= mode;
`endif
          end
        end
        CALC: begin
          a_q  <= a_q >> LIMB;
          b_q  <= b_q >> LIMB;
          p_q  <= p_q >> LIMB;
          s_q  <= (s_q >> LIMB) | s_ins;
          d_q  <= (d_q >> LIMB) | d_ins;
          r1_q <= r1_d;
          r2_q <= r2_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= FINAL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FINAL: begin
          out_q   <= sel_d ? d_q : s_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ffa_limb_serial.sv
// Directed self-checking bench for ffa_limb_serial (default 256/64, secp256k1).
module tb_ffa_limb_serial;

  localparam logic [255:0] PR = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [255:0] a = '0;
  logic [255:0] b = '0;
  logic [255:0] dout;
  logic         done;
  logic         busy;

  int checks = 0;
  int failures = 0;

  ffa_limb_serial #(.WIDTH(256), .LIMB(64), .P(PR)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .a(a), .b(b), .out(dout), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] va;
    logic [255:0] vb;
    logic         vm;
    logic [255:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [255:0] va, input logic [255:0] vb,
                         input logic vm, input logic [255:0] exp, input string name);
    vec_t v;
    v.va = va; v.vb = vb; v.vm = vm; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts an operation and counts edges from the accepting edge until done.
  task automatic do_op(input logic [255:0] ta, input logic [255:0] tb, input logic tm,
                       input string name, output logic [255:0] res, output int lat);
    a = ta; b = tb; mode = tm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_busy"}, {255'd0, busy}, 256'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = dout;
  endtask

  logic [255:0] r;
  int           lat;
  logic         seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add_vec(256'd10, 256'd15, 1'b0, 256'd25, "add_small");
    add_vec(PR - 256'd1, 256'd1, 1'b0, 256'd0, "add_wrap_to_zero");
    add_vec(PR - 256'd1, PR - 256'd1, 1'b0, PR - 256'd2, "add_carry_out");
    add_vec(256'd0, 256'd0, 1'b0, 256'd0, "add_zero");
    add_vec(PR - 256'd2, 256'd5, 1'b0, 256'd3, "add_over_p");
    add_vec(256'd1 << 255, 256'd1 << 255, 1'b0, 256'h1_000003D1, "add_two_pow_256");
    add_vec(256'hFFFFFFFF_FFFFFFFF, 256'd1, 1'b0, 256'h1_00000000_00000000, "add_limb_carry");
`ifdef FFA_SUB_EN
    add_vec(256'd10, 256'd15, 1'b1, PR - 256'd5, "sub_neg");
    add_vec(256'd15, 256'd10, 1'b1, 256'd5, "sub_pos");
    add_vec(256'd0, 256'd1, 1'b1, PR - 256'd1, "sub_zero_minus_one");
    add_vec(PR - 256'd1, PR - 256'd1, 1'b1, 256'd0, "sub_equal");
`else
    add_vec(256'd10, 256'd15, 1'b1, 256'd25, "mode_ignored_a");
    add_vec(256'd15, 256'd10, 1'b1, 256'd25, "mode_ignored_b");
    add_vec(PR - 256'd1, 256'd1, 1'b1, 256'd0, "mode_ignored_wrap");
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", dout, 256'd0);
    chk("reset_done", {255'd0, done}, 256'd0);
    chk("reset_busy", {255'd0, busy}, 256'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vm, vecs[i].name, r, lat);
      chk(vecs[i].name, r, vecs[i].exp);
      chk({vecs[i].name, "_lat"}, 256'(lat), 256'd5);
      chk({vecs[i].name, "_busy_end"}, {255'd0, busy}, 256'd0);
      @(posedge clk); #1;
    end

    // Out-of-range operands: no hang, same latency
    do_op('1, '1, 1'b0, "oor", r, lat);
    chk("oor_lat", 256'(lat), 256'd5);
    @(posedge clk); #1;

    // Start held high: back-to-back ops with single-cycle done pulse
    a = 256'd3; b = 256'd4; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("held_lat1", 256'(lat), 256'd5);
    chk("held_res1", dout, 256'd7);
    a = PR - 256'd1; b = 256'd2;
    @(posedge clk); #1;
    chk("held_done_pulse", {255'd0, done}, 256'd0);
    chk("held_busy2", {255'd0, busy}, 256'd1);
    chk("held_out_kept", dout, 256'd7);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("held_lat2", 256'(lat), 256'd5);
    chk("held_res2", dout, 256'd1);
    @(posedge clk); #1;

    // Start and operand changes during CALC are ignored; out holds until FINAL
    a = 256'd1000; b = 256'd2000; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 256'd5; b = 256'd6; mode = 1'b1;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    chk("ign_out_hold", dout, 256'd1);
    chk("ign_busy", {255'd0, busy}, 256'd1);
    start = 1'b0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("ign_lat", 256'(lat), 256'd5);
    chk("ign_res", dout, 256'd3000);
    @(posedge clk); #1;

    // Reset in the middle of CALC aborts the operation
    a = 256'd100; b = 256'd200; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("abort_out", dout, 256'd0);
    chk("abort_busy", {255'd0, busy}, 256'd0);
    chk("abort_done", {255'd0, done}, 256'd0);
    #2;
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    chk("abort_no_done", {255'd0, seen}, 256'd0);
    chk("abort_out_still0", dout, 256'd0);
    do_op(256'd7, 256'd8, 1'b0, "after_abort", r, lat);
    chk("after_abort", r, 256'd15);
    chk("after_abort_lat", 256'(lat), 256'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
